// File: rtl/options_serializer_if.sv
// options_serializer_if: request and byte-stream signals between the option builder and the serializer.
interface options_serializer_if;
  logic        req_valid;
  logic        req_ready;
  logic        has_start;
  logic        has_info;
  logic        has_data;
  logic        has_end;
  logic [7:0]  info_contents;
  logic [2:0]  data_len;
  logic [39:0] data_contents;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_type;
  logic [3:0]  out_pos;
  logic        out_last;
  logic        done;
  logic        is_empty;
  logic        has_error;
  modport master (
    output req_valid, has_start, has_info, has_data, has_end,
           info_contents, data_len, data_contents, out_ready,
    input  req_ready, out_valid, out_data, out_type, out_pos, out_last,
           done, is_empty, has_error
  );
  modport slave (
    input  req_valid, has_start, has_info, has_data, has_end,
           info_contents, data_len, data_contents, out_ready,
    output req_ready, out_valid, out_data, out_type, out_pos, out_last,
           done, is_empty, has_error
  );
endinterface

// File: rtl/options_serializer.sv
// options_serializer: emits one registered option request as a byte stream
// (START, INFO, INFOCONTENTS, DATA, DATALEN, DATACONTENTS..., ENDOPTION).
module options_serializer #(
  parameter logic [7:0] START_CODE = 8'hA0,
  parameter logic [7:0] INFO_CODE  = 8'hB0,
  parameter logic [7:0] DATA_CODE  = 8'hC0,
  parameter logic [7:0] END_CODE   = 8'hFF,
  parameter int         MAX_DATA   = 5
) (
  input logic clk,
  input logic rst_n,
  options_serializer_if.slave bus
);
  typedef enum logic [3:0] {
    S_READY, S_START, S_INFO, S_INFOC, S_DATA, S_DLEN, S_DCONT, S_END, S_DONE
  } state_t;
  state_t      state, nxt, after_xfer;
  logic        f_info, f_data, f_end;
  logic [7:0]  info_r;
  logic [2:0]  len_r, idx;
  logic [39:0] cont_r;
  logic [3:0]  pos;
  logic        empty_r, err_r;
  logic        accept, in_err, in_empty, xfer, valid, last;
  logic [7:0]  data;
  logic [2:0]  otype;
  function automatic state_t first_of(logic s, logic i, logic d, logic e);
    return s ? S_START : i ? S_INFO : d ? S_DATA : e ? S_END : S_DONE;
  endfunction
  always_comb begin
    accept   = bus.req_valid && state == S_READY;
    in_err   = bus.has_data && 32'(bus.data_len) > MAX_DATA;
    in_empty = !(bus.has_start || bus.has_info || bus.has_data || bus.has_end);
    valid    = !(state inside {S_READY, S_DONE});
    xfer     = valid && bus.out_ready;
    case (state)
      S_START: after_xfer = first_of(1'b0, f_info, f_data, f_end);
      S_INFO:  after_xfer = S_INFOC;
      S_INFOC: after_xfer = first_of(1'b0, 1'b0, f_data, f_end);
      S_DATA:  after_xfer = S_DLEN;
      S_DLEN:  after_xfer = len_r != 3'd0 ? S_DCONT : (f_end ? S_END : S_DONE);
      S_DCONT: after_xfer = idx == len_r - 3'd1 ? (f_end ? S_END : S_DONE) : S_DCONT;
      default: after_xfer = S_DONE;
    endcase
    // The final byte of a frame is whichever byte would lead straight to DONE.
    last = valid && after_xfer == S_DONE;
    nxt = state;
    if (accept)
      nxt = (in_err || in_empty) ? S_DONE
          : first_of(bus.has_start, bus.has_info, bus.has_data, bus.has_end);
    else if (state == S_DONE)
      nxt = S_READY;
    else if (xfer)
      nxt = after_xfer;
    case (state)
      S_START: begin data = START_CODE;           otype = 3'd0; end
      S_INFO:  begin data = INFO_CODE;            otype = 3'd2; end
      S_INFOC: begin data = info_r;               otype = 3'd3; end
      S_DATA:  begin data = DATA_CODE;            otype = 3'd4; end
      S_DLEN:  begin data = {5'b0, len_r};        otype = 3'd5; end
      S_DCONT: begin data = cont_r[{idx, 3'b000} +: 8]; otype = 3'd6; end
      S_END:   begin data = END_CODE;             otype = 3'd1; end
      default: begin data = 8'h00;                otype = 3'd0; end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_READY;
      f_info  <= 1'b0;
      f_data  <= 1'b0;
      f_end   <= 1'b0;
      info_r  <= 8'h00;
      len_r   <= 3'd0;
      cont_r  <= '0;
      idx     <= 3'd0;
      pos     <= 4'd0;
      empty_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        f_info  <= bus.has_info;
        f_data  <= bus.has_data;
        f_end   <= bus.has_end;
        info_r  <= bus.info_contents;
        len_r   <= bus.data_len;
        cont_r  <= bus.data_contents;
        idx     <= 3'd0;
        pos     <= 4'd0;
        empty_r <= in_empty;
        err_r   <= in_err;
      end else if (xfer) begin
        pos <= pos + 4'd1;
        if (state == S_DCONT) idx <= idx + 3'd1;
      end
    end
  end
  assign bus.req_ready = state == S_READY;
  assign bus.out_valid = valid;
  assign bus.out_data  = valid ? data : 8'h00;
  assign bus.out_type  = valid ? otype : 3'd0;
  assign bus.out_pos   = valid ? pos : 4'd0;
  assign bus.out_last  = last;
  assign bus.done      = state == S_DONE;
  assign bus.is_empty  = state == S_DONE && empty_r;
  assign bus.has_error = state == S_DONE && err_r;
endmodule

// File: tb/tb_options_serializer.sv
// tb_options_serializer: randomized and directed frames checked against a byte-queue model of the option stream.
module tb_options_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  options_serializer_if bus();
  options_serializer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [10:0] exp_q[$];
  logic [7:0]  got[$];
  bit busy = 0, pend_done = 0, m_empty = 0, m_err = 0;
  int m_pos = 0;
  int mode = 0, pat = 0;
  int d_lat;
  logic d_empty, d_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    pat++;
    bus.out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom) : (pat % 4 == 0 || pat % 4 == 3);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_ready", bus.req_ready, 1);
      chk("rst_done", bus.done, 0);
      exp_q.delete();
      busy = 0; pend_done = 0;
    end else begin
      if (busy && !pend_done) begin
        chk("out_valid", bus.out_valid, 1);
        chk("out_data", bus.out_data, exp_q[0][7:0]);
        chk("out_type", bus.out_type, exp_q[0][10:8]);
        chk("out_pos", bus.out_pos, m_pos);
        chk("out_last", bus.out_last, exp_q.size() == 1);
      end else chk("out_valid_idle", bus.out_valid, 0);
      chk("done", bus.done, pend_done);
      if (pend_done) begin
        chk("is_empty", bus.is_empty, m_empty);
        chk("has_error", bus.has_error, m_err);
      end
      chk("req_ready", bus.req_ready, !busy);
      if (pend_done) begin
        pend_done = 0; busy = 0;
      end else if (busy && bus.out_ready) begin
        got.push_back(bus.out_data);
        void'(exp_q.pop_front());
        m_pos++;
        if (exp_q.size() == 0) pend_done = 1;
      end else if (!busy && bus.req_valid) begin
        m_err = bus.has_data && bus.data_len > 5;
        m_empty = !(bus.has_start || bus.has_info || bus.has_data || bus.has_end);
        if (!m_err) begin
          if (bus.has_start) exp_q.push_back({3'd0, 8'hA0});
          if (bus.has_info) begin
            exp_q.push_back({3'd2, 8'hB0});
            exp_q.push_back({3'd3, bus.info_contents});
          end
          if (bus.has_data) begin
            exp_q.push_back({3'd4, 8'hC0});
            exp_q.push_back({3'd5, 5'b0, bus.data_len});
            for (int k = 0; k < int'(bus.data_len); k++)
              exp_q.push_back({3'd6, bus.data_contents[8*k +: 8]});
          end
          if (bus.has_end) exp_q.push_back({3'd1, 8'hFF});
        end
        busy = 1; m_pos = 0;
        if (exp_q.size() == 0) pend_done = 1;
      end
    end
  end

  task automatic scramble();
    bus.has_start = 1'($urandom); bus.has_info = 1'($urandom);
    bus.has_data = 1'($urandom); bus.has_end = 1'($urandom);
    bus.info_contents = 8'($urandom); bus.data_len = 3'($urandom);
    bus.data_contents = {8'($urandom), 32'($urandom)};
  endtask

  task automatic send(input logic s, i, d, e, input logic [7:0] info,
                      input logic [2:0] len, input logic [39:0] c);
    int n = 0;
    while (!bus.req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.req_ready) chk("ready_timeout", 0, 1);
    got.delete();
    {bus.has_start, bus.has_info, bus.has_data, bus.has_end} = {s, i, d, e};
    bus.info_contents = info; bus.data_len = len; bus.data_contents = c;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    scramble();
    d_lat = 0;
    do begin @(negedge clk); d_lat++; end while (!bus.done && d_lat < 200);
    if (!bus.done) chk("done_timeout", 0, 1);
    d_empty = bus.is_empty; d_err = bus.has_error;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] e1[9] = '{8'hA0, 8'hB0, 8'h55, 8'hC0, 8'h03, 8'h11, 8'h22, 8'h33, 8'hFF};
    logic [7:0] e5[7] = '{8'hC0, 8'h05, 8'hc0, 8'hc1, 8'hc2, 8'hc3, 8'hc4};
    int n;
    bus.req_valid = 0; bus.out_ready = 1;
    {bus.has_start, bus.has_info, bus.has_data, bus.has_end} = 4'b0;
    bus.info_contents = 0; bus.data_len = 0; bus.data_contents = 0;
    #3;
    chk("reset_ready", bus.req_ready, 1);
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_done", bus.done, 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    // All options present.
    send(1, 1, 1, 1, 8'h55, 3'd3, {16'h0, 8'h33, 8'h22, 8'h11});
    chk("all_count", got.size(), 9);
    for (int k = 0; k < 9 && k < got.size(); k++) chk("all_byte", got[k], e1[k]);
    chk("all_lat", d_lat, 10);
    chk("all_flags", {d_empty, d_err}, 2'b00);
    // START and END only.
    send(1, 0, 0, 1, 8'h00, 3'd0, 40'h0);
    chk("se_count", got.size(), 2);
    if (got.size() == 2) begin chk("se_b0", got[0], 8'hA0); chk("se_b1", got[1], 8'hFF); end
    // Oversize data length is rejected.
    send(0, 0, 1, 0, 8'h00, 3'd6, 40'h0);
    chk("err_count", got.size(), 0);
    chk("err_lat", d_lat, 1);
    chk("err_flag", d_err, 1);
    // No flags set.
    send(0, 0, 0, 0, 8'h12, 3'd2, 40'h0);
    chk("empty_count", got.size(), 0);
    chk("empty_flag", d_empty, 1);
    // Stalled delivery of a full data option.
    mode = 2;
    send(0, 0, 1, 0, 8'h00, 3'd5, 40'hc4c3c2c1c0);
    chk("stall_count", got.size(), 7);
    for (int k = 0; k < 7 && k < got.size(); k++) chk("stall_byte", got[k], e5[k]);
    // Asynchronous reset in the middle of the content bytes.
    mode = 0;
    {bus.has_start, bus.has_info, bus.has_data, bus.has_end} = 4'b0011;
    bus.data_len = 3'd5; bus.data_contents = 40'h0504030201;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus.out_valid && bus.out_type == 3'd6 && bus.out_pos == 4'd3) && n < 50);
    chk("mid_dcont_reached", bus.out_type, 6);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_valid", bus.out_valid, 0);
    chk("async_ready", bus.req_ready, 1);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(1, 0, 0, 1, 8'h00, 3'd0, 40'h0);
    chk("post_rst_count", got.size(), 2);
    if (got.size() > 0) chk("post_rst_b0", got[0], 8'hA0);
    // Random frames with random backpressure.
    mode = 1;
    repeat (150) begin
      send(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
           3'($urandom_range(0, 7)), {8'($urandom), 32'($urandom)});
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/options_serializer.md
Name: options_serializer

Overview:
- Transmit-side counterpart of the options parser. Takes one set of parsed option fields and emits the option stream one byte per cycle, in the order the parser expects.
- Sits between the option-building control logic and the byte channel that feeds the parser. A frame is at most 11 bytes, which is within the parser's 15-byte window.
- Emitted order: START, INFO, INFOCONTENTS, DATA, DATALEN, DATACONTENTS[0..len-1], ENDOPTION. Absent options are skipped.

Parameters:
- START_CODE, 8'hA0, byte emitted for the START option.
- INFO_CODE, 8'hB0, byte emitted for the INFO option.
- DATA_CODE, 8'hC0, byte emitted for the DATA option.
- END_CODE, 8'hFF, byte emitted for the ENDOPTION option.
- MAX_DATA, 5, maximum number of DATACONTENTS bytes.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  serializer idle and able to accept a request.
- has_start  in  1  emit START.
- has_info  in  1  emit INFO plus its contents byte.
- has_data  in  1  emit DATA, DATALEN and the content bytes.
- has_end  in  1  emit ENDOPTION.
- info_contents  in  8  INFOCONTENTS byte.
- data_len  in  3  number of content bytes, 0..MAX_DATA.
- data_contents  in  40  content bytes; byte i is [8i+7:8i], byte 0 is sent first.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the byte.
- out_data  out  8  stream byte.
- out_type  out  3  e_options encoding of the current byte: START=0, ENDOPTION=1, INFO=2, INFOCONTENTS=3, DATA=4, DATALEN=5, DATACONTENTS=6.
- out_pos  out  4  stream position of the current byte, 0-based.
- out_last  out  1  current byte is the final byte of the frame.
- done  out  1  one-cycle pulse when the frame completes.
- is_empty  out  1  qualifies done: the request had no option flags set.
- has_error  out  1  qualifies done: the request was rejected.

Behaviour:
- Reset values: all outputs 0 except req_ready=1. State is READY.
- Reset is asynchronous and can occur mid-frame. The partial frame is abandoned: out_valid drops immediately and no done pulse is generated.
- States: READY, START, INFO, INFOC, DATA, DLEN, DCONT, END, DONE.
- Acceptance: a request is accepted when req_valid && req_ready.
  - All inputs are registered at acceptance.
  - req_ready is 0 from the cycle after acceptance until the cycle after done.
- Routing from READY on acceptance:
  - data_len > MAX_DATA with has_data=1: go to DONE, has_error=1, no bytes emitted.
  - No flags set: go to DONE, is_empty=1, no bytes emitted.
  - Otherwise: go to the first enabled option state.
- Latency: the first byte has out_valid=1 in the cycle after acceptance.
- Handshake:
  - A byte transfers on out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_type, out_pos and out_last hold stable.
  - out_valid never drops without a transfer, except on reset.
- Progression: after each transfer, the FSM moves to the next enabled state in the emitted order.
  - DCONT repeats data_len times, using an internal index 0..data_len-1.
  - has_data with data_len=0 emits DATA and DLEN=8'h00, then skips DCONT.
- Byte values:
  - DLEN emits {5'b0, data_len}.
  - INFOC emits info_contents.
  - DCONT emits the content byte at the current index.
- out_pos starts at 0 for each frame and increments by 1 per transfer. Maximum is 10; it never wraps within a frame.
- out_last=1 on the last enabled byte of the frame. That byte is END if has_end; otherwise it is the last byte of the last enabled option.
- DONE lasts one cycle:
  - done=1, is_empty and has_error valid in that cycle, then return to READY.
  - DONE is entered the cycle after the out_last transfer.
- A new request may be accepted in the READY cycle after DONE. There are no back-to-back frames without the DONE cycle.
- Input changes while busy are ignored.

Test Plan:
- All flags set, info=8'h55, len=3, contents bytes 11,22,33, out_ready=1 → 9 bytes A0,B0,55,C0,03,11,22,33,FF; out_pos 0..8; out_last on FF; done one cycle later with is_empty=0 and has_error=0.
- has_start+has_end only → A0 then FF at pos 0,1; out_last on FF; done.
- has_data with len=6 → no out_valid; done with has_error=1 in the cycle after acceptance; req_ready back to 1 the following cycle.
- No flags → done with is_empty=1; zero bytes emitted.
- len=5, out_ready toggling 1,0,0,1 pattern → payload stable across stalls; bytes C0,05,c0..c4 delivered in order with no duplicates or losses.
- Assert rst_n low mid-DCONT with len=5 → out_valid=0 and req_ready=1 immediately; no done; the next request starts at pos 0.
